// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result handshake bundle for the serial adder
interface serial_adder_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder, one result bit per clock
module serial_adder #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  serial_adder_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  logic [1:0]       state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             hs1, hc1, fs, hc2, fc;
  // full adder from two half-adder stages on the current operand LSBs
  always_comb begin
    hs1 = op_a[0] ^ op_b[0];
    hc1 = op_a[0] & op_b[0];
    fs  = hs1 ^ carry;
    hc2 = hs1 & carry;
    fc  = hc1 | hc2;
  end
  // control and datapath: latch on input handshake, shift WIDTH times, hold until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_a  <= '0;
      op_b  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (state == IDLE) begin
      if (bus.in_valid) begin
        state <= SHIFT;
        op_a  <= bus.a;
        op_b  <= bus.b;
        carry <= bus.cin;
        cnt   <= '0;
      end
    end else if (state == SHIFT) begin
      res   <= {fs, res[WIDTH-1:1]};
      op_a  <= op_a >> 1;
      op_b  <= op_b >> 1;
      carry <= fc;
      cnt   <= cnt + CW'(1);
      if (cnt == CW'(WIDTH - 1)) state <= DONE;
    end else if (state == DONE) begin
      if (bus.out_ready) state <= IDLE;
    end else begin
      state <= IDLE;
    end
  end
  assign bus.in_ready  = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.busy      = state != IDLE;
  assign bus.sum       = res;
  assign bus.cout      = carry;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed checks of the bit-serial adder
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  serial_adder_if #(.WIDTH(8)) bus ();
  serial_adder #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run_op(input string tag, input logic [7:0] x, input logic [7:0] y,
                        input logic c, input logic [7:0] es, input logic ec);
    int lat;
    bus.a = x;
    bus.b = y;
    bus.cin = c;
    bus.in_valid = 1'b1;
    check({tag, "_in_ready"}, 32'(bus.in_ready), 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = ~x;
    bus.b = y ^ 8'h5A;
    bus.cin = ~c;
    check({tag, "_busy"}, 32'(bus.busy), 1);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 8);
    check({tag, "_sum"}, 32'(bus.sum), 32'(es));
    check({tag, "_cout"}, 32'(bus.cout), 32'(ec));
  endtask
  task automatic take(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "_taken_valid"}, 32'(bus.out_valid), 0);
    check({tag, "_taken_ready"}, 32'(bus.in_ready), 1);
  endtask
  initial begin
    logic [7:0] va [4] = '{8'h01, 8'h80, 8'h7F, 8'hC3};
    logic [7:0] vb [4] = '{8'h02, 8'h80, 8'h01, 8'h3D};
    logic       vc [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [8:0] expq [$];
    int hs, got, cyc, last_hs;
    bit acc;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sum", 32'(bus.sum), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    take("zero");
    run_op("wrap", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    take("wrap");
    run_op("a5", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
    take("a5");
    run_op("3c", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i % 2) == 0;
      @(posedge clk); #1;
      check("hold_valid", 32'(bus.out_valid), 1);
      check("hold_sum", 32'(bus.sum), 32'h4B);
      check("hold_cout", 32'(bus.cout), 0);
      check("hold_in_ready", 32'(bus.in_ready), 0);
    end
    bus.in_valid = 1'b0;
    take("3c");
    bus.a = 8'hF0;
    bus.b = 8'h0F;
    bus.cin = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_sum", 32'(bus.sum), 0);
    check("abort_cout", 32'(bus.cout), 0);
    check("abort_out_valid", 32'(bus.out_valid), 0);
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_in_ready", 32'(bus.in_ready), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_result", 32'(bus.out_valid), 0);
    run_op("after_rst", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
    take("after_rst");
    hs = 0;
    got = 0;
    cyc = 0;
    last_hs = -1;
    bus.out_ready = 1'b1;
    bus.a = va[0];
    bus.b = vb[0];
    bus.cin = vc[0];
    bus.in_valid = 1'b1;
    while (got < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      acc = bus.in_valid && bus.in_ready;
      if (acc) begin
        if (last_hs >= 0) check("b2b_gap", 32'(cyc - last_hs), 10);
        last_hs = cyc;
        expq.push_back(9'(bus.a) + 9'(bus.b) + 9'(bus.cin));
        hs++;
      end
      if (bus.out_valid) begin
        if (expq.size() > 0) check("b2b_result", 32'({bus.cout, bus.sum}), 32'(expq.pop_front()));
        else check("b2b_unexpected", 32'(bus.out_valid), 0);
        got++;
      end
      @(posedge clk); #1;
      if (acc) begin
        if (hs < 4) begin
          bus.a = va[hs];
          bus.b = vb[hs];
          bus.cin = vc[hs];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    check("b2b_count", 32'(got), 4);
    bus.out_ready = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
